// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester arbiter for the data port of the unified
// instruction/data memory. Requester 0 is the core LSU, requester 1 is the
// program loader / debug master. One memory access per transaction:
// accept (IDLE) -> memory access (ACCESS) -> response strobe (RESP).
//
// Handshake: a request transfers in the cycle where pN_req_valid and
// pN_req_ready are both high; ready is only ever raised in IDLE for the single
// winner, and the requester holds valid and all fields until it sees ready.
// pN_resp_valid is a one-cycle strobe that needs no acknowledgement.
//
// Build option: define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// left undefined, requester 0 has fixed priority.
module mem_port_arbiter #(
  parameter int unsigned INST_SIZE_IN_BYTE     = 16384,
  parameter int unsigned DATA_SIZE_IN_BYTE     = 16384,
  parameter bit          ALLOW_CORE_INST_WRITE = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req_valid,
  output logic        p0_req_ready,
  input  logic [31:0] p0_req_addr,
  input  logic        p0_req_write,
  input  logic [3:0]  p0_req_width,
  input  logic [31:0] p0_req_wdata,
  output logic        p0_resp_valid,
  input  logic        p1_req_valid,
  output logic        p1_req_ready,
  input  logic [31:0] p1_req_addr,
  input  logic        p1_req_write,
  input  logic [3:0]  p1_req_width,
  input  logic [31:0] p1_req_wdata,
  output logic        p1_resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_addr,
  output logic        mem_write_enable,
  output logic [3:0]  mem_write_width,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Region limits widened to 33 bits so the end-address compare sees wrap.
  localparam logic [32:0] INST_LIMIT = 33'(INST_SIZE_IN_BYTE);
  localparam logic [32:0] MAP_LIMIT  = 33'(INST_SIZE_IN_BYTE) + 33'(DATA_SIZE_IN_BYTE);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        write_q, write_d;
  logic        err_q, err_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_width_q, mem_width_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic        rr_q, rr_d;  // 1 = requester 1 wins the next contended cycle
`endif

  logic        pick1;
  logic [31:0] sel_addr;
  logic        sel_write;
  logic [3:0]  sel_width;
  logic [31:0] sel_wdata;
  logic [32:0] sel_end;
  logic        width_bad, range_bad, in_inst, straddle, core_inst_wr;

  // Arbitration, accept-time legality check and next-state logic.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    write_d      = write_q;
    err_d        = err_q;
    mem_addr_d   = mem_addr_q;
    mem_width_d  = mem_width_q;
    mem_wdata_d  = mem_wdata_q;
    p0_req_ready = 1'b0;
    p1_req_ready = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    rr_d  = rr_q;
    pick1 = p1_req_valid && (!p0_req_valid || rr_q);
`else
    pick1 = p1_req_valid && !p0_req_valid;
`endif
    sel_addr  = pick1 ? p1_req_addr  : p0_req_addr;
    sel_write = pick1 ? p1_req_write : p0_req_write;
    sel_width = pick1 ? p1_req_width : p0_req_width;
    sel_wdata = pick1 ? p1_req_wdata : p0_req_wdata;

    sel_end      = {1'b0, sel_addr} + {29'd0, sel_width} - 33'd1;
    width_bad    = !(sel_width == 4'd1 || sel_width == 4'd2 || sel_width == 4'd4);
    range_bad    = sel_end >= MAP_LIMIT;
    in_inst      = {1'b0, sel_addr} < INST_LIMIT;
    straddle     = in_inst && (sel_end >= INST_LIMIT);
    core_inst_wr = !pick1 && sel_write && in_inst && !ALLOW_CORE_INST_WRITE;

    unique case (state_q)
      IDLE: begin
        if (rst_n && (p0_req_valid || p1_req_valid)) begin
          p0_req_ready = !pick1;
          p1_req_ready = pick1;
          owner_d      = pick1;
          write_d      = sel_write;
          err_d        = width_bad || range_bad || straddle || core_inst_wr;
          mem_addr_d   = sel_addr;
          mem_width_d  = sel_width;
          mem_wdata_d  = sel_wdata;
          state_d      = ACCESS;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          rr_d         = !pick1;
`endif
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and transaction registers; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_width_q <= '0;
      mem_wdata_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      write_q     <= write_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr_d;
      mem_width_q <= mem_width_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_q        <= rr_d;
`endif
    end
  end

  // Memory port: fields hold outside ACCESS, the write strobe does not.
  assign mem_addr         = mem_addr_q;
  assign mem_write_width  = mem_width_q;
  assign mem_write_data   = mem_wdata_q;
  assign mem_write_enable = (state_q == ACCESS) && write_q && !err_q;

  // Response: memory read data arrives the cycle after ACCESS, i.e. in RESP.
  assign p0_resp_valid = (state_q == RESP) && !owner_q;
  assign p1_resp_valid = (state_q == RESP) && owner_q;
  assign resp_error    = (state_q == RESP) && err_q;
  assign resp_rdata    = ((state_q == RESP) && !write_q && !err_q) ? mem_read_data : 32'd0;

  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed cases plus randomized traffic, checked
// by a reference model (byte-array memory + address-map rules) feeding a
// response queue and a memory-write queue that separate monitors drain.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam longint unsigned INST  = 16384;
  localparam longint unsigned MAP   = 32768;
  localparam bit              ALLOW = 1'b0;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [3:0]  width;
    logic [31:0] wdata;
  } req_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        p0_req_valid = 0, p1_req_valid = 0;
  logic        p0_req_ready, p1_req_ready, p0_resp_valid, p1_resp_valid;
  logic [31:0] p0_req_addr = 0, p1_req_addr = 0, p0_req_wdata = 0, p1_req_wdata = 0;
  logic        p0_req_write = 0, p1_req_write = 0;
  logic [3:0]  p0_req_width = 0, p1_req_width = 0;
  logic [31:0] resp_rdata, mem_addr, mem_write_data;
  logic [31:0] mem_read_data = 0;
  logic        resp_error, mem_write_enable;
  logic [3:0]  mem_write_width;
  logic [1:0]  dbg_state;

  mem_port_arbiter #(
    .INST_SIZE_IN_BYTE(16384), .DATA_SIZE_IN_BYTE(16384), .ALLOW_CORE_INST_WRITE(ALLOW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_addr(p0_req_addr),
    .p0_req_write(p0_req_write), .p0_req_width(p0_req_width), .p0_req_wdata(p0_req_wdata),
    .p0_resp_valid(p0_resp_valid),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_addr(p1_req_addr),
    .p1_req_write(p1_req_write), .p1_req_width(p1_req_width), .p1_req_wdata(p1_req_wdata),
    .p1_resp_valid(p1_resp_valid),
    .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_addr(mem_addr), .mem_write_enable(mem_write_enable),
    .mem_write_width(mem_write_width), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .dbg_state(dbg_state)
  );

  // ---------------- memory attached to the DUT ----------------
  logic [7:0] phys [0:32767];
  always @(posedge clk) begin
    if (mem_write_enable)
      for (int i = 0; i < 4; i++)
        if (i < int'(mem_write_width)) phys[15'(mem_addr + 32'(i))] <= mem_write_data[8*i +: 8];
    mem_read_data <= {phys[15'(mem_addr + 32'd3)], phys[15'(mem_addr + 32'd2)],
                      phys[15'(mem_addr + 32'd1)], phys[15'(mem_addr)]};
  end

  // ---------------- scoreboard ----------------
  logic [7:0]  refm [0:32767];
  logic [33:0] exp_q[$];   // {owner, err, rdata}
  logic [67:0] wexp_q[$];  // {addr, width, wdata}
  req_t        q0[$], q1[$];
  bit          favor1 = 1'b0;
  int          n_checks = 0, n_miss = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model of one accepted request.
  task automatic model_accept(input bit owner, input req_t r, input bit want_resp, output bit we);
    longint unsigned last;
    bit              err;
    logic [31:0]     rd;
    last = longint'(r.addr) + longint'(r.width) - 1;
    err  = !(r.width inside {4'd1, 4'd2, 4'd4}) || (last >= MAP) ||
           (longint'(r.addr) < INST && last >= INST) ||
           (!owner && r.write && longint'(r.addr) < INST && !ALLOW);
    we = r.write && !err;
    if (we) begin
      for (int i = 0; i < int'(r.width); i++) refm[15'(r.addr + 32'(i))] = r.wdata[8*i +: 8];
      wexp_q.push_back({r.addr, r.width, r.wdata});
    end
    rd = 32'd0;
    if (!r.write && !err)
      for (int i = 0; i < 4; i++) rd[8*i +: 8] = refm[15'(r.addr + 32'(i))];
    if (want_resp) exp_q.push_back({owner, err, rd});
  endtask

  // Response monitor.
  always @(negedge clk) begin
    if (p0_resp_valid || p1_resp_valid) begin
      if (exp_q.size() == 0) check("resp_unexpected", {p1_resp_valid, p0_resp_valid}, 0);
      else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        check("resp", {p1_resp_valid, p0_resp_valid, resp_error, resp_rdata},
              {e[33], ~e[33], e[32], e[31:0]});
      end
    end
  end

  // Memory-write monitor.
  always @(negedge clk) begin
    if (mem_write_enable) begin
      if (wexp_q.size() == 0) check("write_unexpected", {mem_addr, mem_write_width, mem_write_data}, 0);
      else check("mem_write", {mem_addr, mem_write_width, mem_write_data}, wexp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic present();
    p0_req_valid = (q0.size() > 0);
    p1_req_valid = (q1.size() > 0);
    if (q0.size() > 0) begin
      p0_req_addr = q0[0].addr; p0_req_write = q0[0].write;
      p0_req_width = q0[0].width; p0_req_wdata = q0[0].wdata;
    end
    if (q1.size() > 0) begin
      p1_req_addr = q1[0].addr; p1_req_write = q1[0].write;
      p1_req_width = q1[0].width; p1_req_wdata = q1[0].wdata;
    end
  endtask

  task automatic run_queues();
    int   budget;
    bit   w, we;
    req_t r;
    budget = 8 * (q0.size() + q1.size()) + 10;
    @(posedge clk); #1;
    while ((q0.size() > 0 || q1.size() > 0) && budget > 0) begin
      present();
      @(negedge clk);
      budget--;
      if (p0_req_ready || p1_req_ready) begin
        if (q0.size() > 0 && q1.size() > 0) w = RR ? favor1 : 1'b0;
        else w = (q0.size() == 0);
        check("grant", {p1_req_ready, p0_req_ready}, w ? 2'b10 : 2'b01);
        r = w ? q1.pop_front() : q0.pop_front();
        model_accept(w, r, 1'b1, we);
        favor1 = !w;
        @(posedge clk); #1;
        present();
        @(negedge clk);
        check("access", {mem_addr, mem_write_enable, mem_write_width, mem_write_data, dbg_state},
              {r.addr, we, r.width, r.wdata, 2'd1});
        @(negedge clk);
        check("resp_cycle", {p1_resp_valid, p0_resp_valid}, w ? 2'b10 : 2'b01);
      end
      @(posedge clk); #1;
    end
    check("drain", q0.size() + q1.size(), 0);
    p0_req_valid = 0;
    p1_req_valid = 0;
  endtask

  function automatic req_t mk(input logic [31:0] a, input bit wr, input logic [3:0] wd, input logic [31:0] d);
    req_t r;
    r.addr = a; r.write = wr; r.width = wd; r.wdata = d;
    return r;
  endfunction

  function automatic req_t rand_req();
    logic [3:0]  widths [7];
    logic [31:0] a;
    widths = '{4'd1, 4'd2, 4'd4, 4'd4, 4'd3, 4'd0, 4'd8};
    case ($urandom_range(0, 5))
      0: a = $urandom_range(0, 32'h7FFF);
      1: a = 32'h3FFC + $urandom_range(0, 7);
      2: a = 32'h7FF8 + $urandom_range(0, 7);
      3: a = $urandom;
      default: a = 32'h4000 + $urandom_range(0, 32'hFF);
    endcase
    return mk(a, 1'($urandom_range(0, 1)), widths[$urandom_range(0, 6)], $urandom);
  endfunction

  task automatic check_reset_vals(input string name);
    check(name, {p0_req_ready, p1_req_ready, p0_resp_valid, p1_resp_valid, resp_error, resp_rdata,
                 mem_addr, mem_write_enable, mem_write_width, mem_write_data, dbg_state}, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit   we;
    bit   seen;
    req_t r;
    for (int i = 0; i < 32768; i++) begin
      phys[i] = 8'(i * 13 + 5);
      refm[i] = 8'(i * 13 + 5);
    end
    phys[16'h4000] = 8'hEF; phys[16'h4001] = 8'hBE; phys[16'h4002] = 8'hAD; phys[16'h4003] = 8'hDE;
    refm[16'h4000] = 8'hEF; refm[16'h4001] = 8'hBE; refm[16'h4002] = 8'hAD; refm[16'h4003] = 8'hDE;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset_state");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed: read, write, read-back, core inst write, error cases.
    q0.push_back(mk(32'h4000, 0, 4'd4, 0));           run_queues();
    q1.push_back(mk(32'h0010, 1, 4'd4, 32'h12345678)); run_queues();
    q0.push_back(mk(32'h0010, 0, 4'd4, 0));           run_queues();
    q0.push_back(mk(32'h0010, 1, 4'd4, 32'hCAFEF00D)); run_queues();
    q1.push_back(mk(32'h7FFE, 1, 4'd4, 32'h11111111));
    q1.push_back(mk(32'h0100, 1, 4'd3, 32'h22222222));
    q1.push_back(mk(32'hFFFFFFFF, 1, 4'd2, 32'h33333333));
    q1.push_back(mk(32'h3FFE, 1, 4'd4, 32'h44444444));
    run_queues();

    // Contended: both requesters valid continuously.
    for (int i = 0; i < 6; i++) begin
      q0.push_back(mk(32'h4100 + 32'(4 * i), 0, 4'd4, 0));
      q1.push_back(mk(32'h4200 + 32'(4 * i), 0, 4'd4, 0));
    end
    run_queues();

    // Reset during ACCESS of a p1 write: write lands, no response.
    r = mk(32'h0020, 1, 4'd4, 32'hA5A5_5A5A);
    @(posedge clk); #1;
    q1.push_back(r);
    present();
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      if (p1_req_ready) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("reset_accept", {seen, p0_req_ready}, 2'b10);
    void'(q1.pop_front());
    model_accept(1'b1, r, 1'b0, we);
    @(posedge clk); #1;
    p1_req_valid = 0;
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_access_we", mem_write_enable, 1'b1);
    @(negedge clk);
    check_reset_vals("reset_after_access");
    @(posedge clk); #1;
    rst_n = 1'b1;
    favor1 = 1'b0;
    q0.push_back(mk(32'h0020, 0, 4'd4, 0));
    run_queues();

    // Randomized traffic.
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 2) != 1) q0.push_back(rand_req());
      if ($urandom_range(0, 2) != 0) q1.push_back(rand_req());
      run_queues();
    end

    repeat (4) @(posedge clk);
    check("exp_q_empty", exp_q.size(), 0);
    check("wexp_q_empty", wexp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter for the data port of the unified instruction/data memory. Requester 0 is the core load/store unit and requester 1 is the program loader/debug master. Each accepted request is decoded against the unified address map (inst region low, data region high) and checked for legal width and range. The arbiter sequences one memory access per transaction and returns read data or an error flag to the owning requester.

## Interface
- INST_SIZE_IN_BYTE, 16384: size of the inst region, mapped at 0x0 to INST_SIZE_IN_BYTE-1.
- DATA_SIZE_IN_BYTE, 16384: size of the data region, mapped directly above the inst region.
- ALLOW_CORE_INST_WRITE, 0: if 1, requester 0 may write the inst region; if 0, such writes are errors.
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- pN_req_valid  in  1  request valid from requester N (N=0,1).
- pN_req_ready  out  1  request accepted this cycle.
- pN_req_addr  in  32  byte address in the unified map.
- pN_req_write  in  1  1 = write, 0 = read.
- pN_req_width  in  4  access size in bytes; legal values are 1, 2, 4.
- pN_req_wdata  in  32  write data, LSB-aligned.
- pN_resp_valid  out  1  one-cycle response strobe to requester N.
- resp_rdata  out  32  read data; shared by both requesters.
- resp_error  out  1  response carries an error; shared by both requesters.
- mem_addr  out  32  address to the memory data port.
- mem_write_enable  out  1  write strobe.
- mem_write_width  out  4  write size.
- mem_write_data  out  32  write data.
- mem_read_data  in  32  read data from memory, valid in the cycle after mem_addr is presented.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any pN_req_valid is high, the arbiter picks a winner, asserts that requester's pN_req_ready combinationally, latches its request and owner ID, and moves to ACCESS. With no request it stays in IDLE.
- Check at accept time, giving a latched err flag; err is set if any of the following holds:
  - width is not 1, 2 or 4;
  - addr+width-1 ≥ INST_SIZE_IN_BYTE+DATA_SIZE_IN_BYTE, computed at 33 bits so wrap is caught;
  - the access straddles the inst/data boundary;
  - owner is 0, the request is a write, the target is the inst region, and ALLOW_CORE_INST_WRITE=0.
- Misaligned addresses are legal.
- ACCESS: mem_* outputs come from flops loaded at accept. mem_write_enable=1 only if the request is a write and err=0. The FSM moves to RESP.
- RESP: the owner's pN_resp_valid=1. resp_error=err. resp_rdata=mem_read_data for a read with err=0; otherwise resp_rdata=0. The FSM moves to IDLE.
- A requester must hold valid and all request fields until it sees ready. The arbiter never accepts while in ACCESS or RESP.
- mem_addr, mem_write_width and mem_write_data hold their last values outside ACCESS. mem_write_enable is 0 outside ACCESS.

## Timing
- Reset values: state=IDLE; pN_req_ready=0, pN_resp_valid=0, resp_rdata=0, resp_error=0; all mem_* outputs=0. The round-robin pointer resets to favour requester 0.
- Latency: accept at cycle T, memory access at T+1, response at T+2. Peak throughput is one transaction per 3 cycles.
- Both requesters valid in the same IDLE cycle: the Configuration policy decides the winner. The loser's ready stays 0 and it retries in the next IDLE.
- Reset mid-transaction:
  - rst_n low in the accept cycle or during ACCESS, sampled at or before the edge that ends ACCESS: the next state is IDLE and no response is issued.
  - A write in ACCESS still lands, because memory samples at the same edge that resets the arbiter.
  - rst_n low during RESP: the strobe in that cycle still occurs, then the arbiter returns to IDLE.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: round-robin arbitration. After each grant, priority moves to the other requester. With a contended request every IDLE, grants alternate 0,1,0,1.
- MEM_ARB_ROUND_ROBIN_EN undefined: fixed priority, with requester 0 always winning. Requester 1 is granted only in IDLE cycles where p0_req_valid=0.

## Test plan
- Reset, then p0 reads 0x4000 with width 4 while memory holds 0xDEADBEEF: p0_req_ready=1 at T, mem_addr=0x4000 at T+1, p0_resp_valid=1 at T+2 with rdata=0xDEADBEEF and resp_error=0.
- p1 writes 0x0010 with width 4 and data 0x12345678: mem_write_enable=1 for exactly one cycle (T+1), resp_error=0. A following p0 read of 0x0010 returns 0x12345678.
- p0 writes 0x0010 with ALLOW_CORE_INST_WRITE=0: mem_write_enable stays 0, p0 gets resp_error=1 and rdata=0.
- Error cases: address 0x7FFE with width 4, width 3, and address 0xFFFFFFFF with width 2 (33-bit wrap). Each gives resp_error=1 and no write.
- Both requesters valid continuously for 6 transactions: with MEM_ARB_ROUND_ROBIN_EN, grants are 0,1,0,1,0,1. Without it, grants are 0,0,0,0,0,0.
- p1 write accepted at T with rst_n low at T+1: the write lands, no p1_resp_valid appears, and outputs are at reset values at T+2.
